// File: rtl/m3_slice_phase_gen.sv
// Slice timer and 6-step commutation phase generator for motor 3.
// Times each slice at a clamped, per-slice shadowed length and emits a once-per-round nextCalc strobe.
module m3_slice_phase_gen #(
  parameter logic [31:0] PERIOD_MIN = 32'd40,
  parameter logic [31:0] PERIOD_MAX = 32'd2_000_000
) (
  input  logic        clkI,
  input  logic        rstI,
  input  logic        workingI,
  input  logic        m3forceStopI,
  input  logic        m3invRotateI,
  input  logic [31:0] dstRoundLenI,
  output logic        sliceTick_1O,
  output logic [2:0]  phaseO,
  output logic        nextCalc_1O,
  output logic        driveEnO,
  output logic [31:0] curSliceLenO
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] slice_cnt_q;
  logic [2:0]  round_cnt_q;
  logic [2:0]  phase_q;
  logic [31:0] cur_len_q;
  logic        drive_en_q;
  logic        tick_q;
  logic        next_calc_q;

  logic [31:0] len_d;
  logic [2:0]  phase_d;
  logic        boundary_d;

  function automatic logic [31:0] clamp_len(input logic [31:0] req);
    if (req < PERIOD_MIN)      return PERIOD_MIN;
    else if (req > PERIOD_MAX) return PERIOD_MAX;
    else                       return req;
  endfunction

  function automatic logic [2:0] step_phase(input logic [2:0] cur, input logic rev);
    if (rev) return (cur == 3'd0) ? 3'd5 : cur - 3'd1;
    else     return (cur == 3'd5) ? 3'd0 : cur + 3'd1;
  endfunction

  assign len_d      = clamp_len(dstRoundLenI);
  assign phase_d    = step_phase(phase_q, m3invRotateI);
  assign boundary_d = (slice_cnt_q == cur_len_q - 32'd1);

  // NOTE: every register below uses <= so all updates see the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clkI) begin
    if (rstI || !workingI) begin
      // Dropping workingI is a soft reset and outranks an emergency stop.
      state_q     <= ST_IDLE;
      slice_cnt_q <= '0;
      round_cnt_q <= '0;
      phase_q     <= '0;
      cur_len_q   <= PERIOD_MAX;
      drive_en_q  <= 1'b0;
      tick_q      <= 1'b0;
      next_calc_q <= 1'b0;
    end else begin
      tick_q      <= 1'b0;
      next_calc_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!m3forceStopI) begin
            state_q     <= ST_RUN;
            cur_len_q   <= len_d;
            slice_cnt_q <= '0;
            round_cnt_q <= '0;
            phase_q     <= '0;
            drive_en_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (m3forceStopI) begin
            // A stop swallows any boundary falling on the same cycle.
            state_q     <= ST_STOP;
            drive_en_q  <= 1'b0;
            slice_cnt_q <= '0;
            round_cnt_q <= '0;
          end else if (boundary_d) begin
            slice_cnt_q <= '0;
            tick_q      <= 1'b1;
            phase_q     <= phase_d;
            cur_len_q   <= len_d;
            round_cnt_q <= (round_cnt_q == 3'd5) ? 3'd0 : round_cnt_q + 3'd1;
            next_calc_q <= (round_cnt_q == 3'd5);
          end else begin
            slice_cnt_q <= slice_cnt_q + 32'd1;
          end
        end
        ST_STOP: begin
          if (!m3forceStopI) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sliceTick_1O = tick_q;
  assign phaseO       = phase_q;
  assign nextCalc_1O  = next_calc_q;
  assign driveEnO     = drive_en_q;
  assign curSliceLenO = cur_len_q;

endmodule

// File: tb/tb_m3_slice_phase_gen.sv
// Randomized and directed bench for m3_slice_phase_gen against a countdown-based behavioural model.
module tb_m3_slice_phase_gen;

  localparam longint P_MIN = 40;
  localparam longint P_MAX = 2_000_000;

  logic        clk = 1'b0;
  logic        rst;
  logic        working;
  logic        force_stop;
  logic        inv_rot;
  logic [31:0] dst_len;
  logic        tick;
  logic [2:0]  phase;
  logic        next_calc;
  logic        drive_en;
  logic [31:0] cur_len;

  m3_slice_phase_gen dut (
    .clkI         (clk),
    .rstI         (rst),
    .workingI     (working),
    .m3forceStopI (force_stop),
    .m3invRotateI (inv_rot),
    .dstRoundLenI (dst_len),
    .sliceTick_1O (tick),
    .phaseO       (phase),
    .nextCalc_1O  (next_calc),
    .driveEnO     (drive_en),
    .curSliceLenO (cur_len)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode, remaining cycles in the slice, ticks since start.
  typedef enum {M_IDLE, M_RUN, M_STOP} mode_t;
  mode_t  m_mode;
  longint m_remain;
  longint m_len;
  int     m_ticks;
  int     m_phase;
  bit     m_tick, m_nc, m_drive;

  function automatic longint clamp(input longint req);
    if (req < P_MIN) return P_MIN;
    if (req > P_MAX) return P_MAX;
    return req;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_remain = 0; m_len = P_MAX; m_ticks = 0;
    m_phase = 0; m_tick = 0; m_nc = 0; m_drive = 0;
  endtask

  task automatic model_step();
    if (rst || !working) begin
      model_reset();
      return;
    end
    m_tick = 0; m_nc = 0;
    case (m_mode)
      M_IDLE: if (!force_stop) begin
        m_mode = M_RUN; m_len = clamp(longint'(dst_len)); m_remain = m_len;
        m_ticks = 0; m_phase = 0; m_drive = 1;
      end
      M_RUN: if (force_stop) begin
        m_mode = M_STOP; m_drive = 0; m_ticks = 0;
      end else begin
        m_remain--;
        if (m_remain == 0) begin
          m_ticks++;
          m_tick = 1;
          m_nc = (m_ticks % 6 == 0);
          m_phase = inv_rot ? (m_phase + 5) % 6 : (m_phase + 1) % 6;
          m_len = clamp(longint'(dst_len));
          m_remain = m_len;
        end
      end
      M_STOP: if (!force_stop) m_mode = M_IDLE;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("tick",     32'(tick),      32'(m_tick));
    check("nextCalc", 32'(next_calc), 32'(m_nc));
    check("phase",    32'(phase),     32'(m_phase));
    check("driveEn",  32'(drive_en),  32'(m_drive));
    check("curLen",   cur_len,        32'(m_len));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic restart(input logic [31:0] len, input logic rev);
    working = 1'b0; cycle();
    dst_len = len; inv_rot = rev; working = 1'b1;
    cycle();
  endtask

  initial begin
    model_reset();
    rst = 1'b1; working = 1'b0; force_stop = 1'b0; inv_rot = 1'b0; dst_len = 32'd40;

    // Reset
    cycles(3);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_len",   cur_len,    32'(P_MAX));
    check("rst_drive", 32'(drive_en), 32'd0);
    rst = 1'b0;

    // Forward steady, 40-cycle slices
    working = 1'b1; dst_len = 32'd40;
    cycles(2 * 6 * 40 + 5);

    // Clamp low and high
    restart(32'd10, 1'b0);
    cycles(130);
    restart(32'hFFFF_FFFF, 1'b0);
    cycles(5);
    check("clamp_hi", cur_len, 32'(P_MAX));

    // Mid-slice length change is shadowed
    restart(32'd100, 1'b0);
    cycles(30);
    dst_len = 32'd60;
    cycles(260);

    // Reverse from start
    restart(32'd40, 1'b1);
    cycles(2 * 6 * 40 + 5);

    // Direction flip while at phase 3
    restart(32'd45, 1'b0);
    for (int i = 0; i < 400 && !(m_phase == 3 && m_remain == 20); i++) cycle();
    check("reach_ph3", 32'(phase), 32'd3);
    inv_rot = 1'b1;
    cycles(25);
    check("flip_rev", 32'(phase), 32'd2);
    cycles(10);
    inv_rot = 1'b0;
    cycles(50);
    check("flip_fwd", 32'(phase), 32'd3);

    // Force stop exactly on a boundary cycle
    restart(32'd50, 1'b0);
    cycles(70);
    for (int i = 0; i < 200 && !(m_mode == M_RUN && m_remain == 1); i++) cycle();
    force_stop = 1'b1;
    cycle();
    check("stop_notick", 32'(tick), 32'd0);
    check("stop_drive",  32'(drive_en), 32'd0);
    check("stop_phase",  32'(phase), 32'd1);
    cycles(3);
    force_stop = 1'b0;
    cycles(2);
    check("restart_ph0", 32'(phase), 32'd0);
    check("restart_drv", 32'(drive_en), 32'd1);
    cycles(120);

    // workingI low mid-slice
    cycles(17);
    working = 1'b0;
    cycle();
    check("wrk_drive", 32'(drive_en), 32'd0);
    check("wrk_len",   cur_len, 32'(P_MAX));
    working = 1'b1;

    // Randomized traffic
    dst_len = 32'd60;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 99) == 0)  dst_len = 32'($urandom_range(0, 140));
      if ($urandom_range(0, 149) == 0) inv_rot = ~inv_rot;
      if (force_stop) begin
        if ($urandom_range(0, 3) == 0) force_stop = 1'b0;
      end else if ($urandom_range(0, 599) == 0) force_stop = 1'b1;
      if (!working) working = 1'b1;
      else if ($urandom_range(0, 999) == 0) working = 1'b0;
      if ($urandom_range(0, 4999) == 0) rst = 1'b1; else rst = 1'b0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
